// File: rtl/pcs_fifo_rd_ptr.sv
// Read-side pointer controller for the 4-entry PCS clock-crossing FIFO.
// Optional protocol checker on err is enabled by defining PCS_RDPTR_CHK_EN.
module pcs_fifo_rd_ptr #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] wr_gray,
    input  logic       rd_en,
    output logic [4:0] rd_gray,
    output logic [1:0] rd_addr,
    output logic       pop_ok,
    output logic       empty,
    output logic [2:0] level,
    output logic       err
);

    localparam int unsigned PTR_W   = 3;
    localparam int unsigned CODE_W  = 5;
    localparam int unsigned DEPTH   = 4;

    logic [CODE_W-1:0] sync_q [SYNC_STAGES];
    logic [CODE_W-1:0] sync_last;
    logic [PTR_W-1:0]  wr_bin_s;
    logic [PTR_W-1:0]  rd_bin;
    logic [PTR_W-1:0]  rd_bin_nxt;
    logic [PTR_W-1:0]  raw;

    // Write-pointer synchroniser; every stage holds a legal code at all times.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= wr_gray;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync_last = sync_q[SYNC_STAGES-1];

    // Gray to binary on the low three bits; the upper two are always zero.
    assign wr_bin_s[2] = sync_last[2];
    assign wr_bin_s[1] = sync_last[2] ^ sync_last[1];
    assign wr_bin_s[0] = sync_last[2] ^ sync_last[1] ^ sync_last[0];

    assign raw     = PTR_W'(wr_bin_s - rd_bin);
    assign level   = (raw > PTR_W'(DEPTH)) ? PTR_W'(DEPTH) : raw;
    assign empty   = (level == '0);
    assign pop_ok  = rd_en & ~empty;
    assign rd_addr = rd_bin[1:0];

    assign rd_bin_nxt = PTR_W'(rd_bin + PTR_W'(1));

    // rd_gray is loaded with the code of the new rd_bin so the two never diverge.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_bin  <= '0;
            rd_gray <= '0;
        end else if (pop_ok) begin
            rd_bin  <= rd_bin_nxt;
            rd_gray <= {2'b00, rd_bin_nxt[2], rd_bin_nxt[2] ^ rd_bin_nxt[1],
                        rd_bin_nxt[1] ^ rd_bin_nxt[0]};
        end
    end

`ifdef PCS_RDPTR_CHK_EN
    // Sticky flag: illegal upper code bits or an occupancy beyond the FIFO depth.
    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if ((sync_last[4:3] != 2'b00) || (raw > PTR_W'(DEPTH))) begin
            err <= 1'b1;
        end
    end
`else
    logic unused_hi;
    assign unused_hi = ^sync_last[4:3];
    assign err       = 1'b0;
`endif

endmodule
